// File: rtl/serial_subtractor_n_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..width-1; at least one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_n_full_adder.sv
// Single-bit full adder cell; the one arithmetic element of the serial
// subtractor.
module full_adder_1 (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_subtractor_n.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock through one
// full-adder cell, with valid/ready handshakes on both sides.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | in_ready=1, waiting for operands
//   ST_RUN  | one result bit per cycle, counter 0..WIDTH-1
//   ST_DONE | out_valid=1, result held until out_ready
module serial_subtractor_n
    import serial_subtractor_n_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
    logic             carry;
    logic             borrow_q, overflow_q;
    logic             b_inv, cell_sum, cell_cout;
    logic             accept, run_last;

    assign accept   = (state == ST_IDLE) && in_valid;
    assign run_last = (state == ST_RUN) && (cnt == LAST);
    assign b_inv    = ~b_sh[0];

    full_adder_1 u_cell (
        .a     (a_sh[0]),
        .b     (b_inv),
        .c_in  (carry),
        .sum   (cell_sum),
        .c_out (cell_cout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cnt == LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Flags are registered at the last bit so they read 0 out of reset
    // and hold through IDLE until the next operation finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            diff_sh    <= '0;
            carry      <= 1'b0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ~borrow_in;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            diff_sh <= {cell_sum, diff_sh[WIDTH-1:1]};
            carry   <= cell_cout;
            if (cnt != LAST) cnt <= cnt + CNT_W'(1);
            if (run_last) begin
                // carry holds c[WIDTH-1], cell_cout is c[WIDTH]
                borrow_q   <= ~cell_cout;
                overflow_q <= carry ^ cell_cout;
            end
        end
    end

    assign diff       = diff_sh;
    assign borrow_out = borrow_q;
    assign overflow   = overflow_q;

endmodule
